// File: rtl/button_conditioner_pkg.sv
// Shared constants and helpers for the push-button conditioning path.
// Board debounce and auto-repeat timing is set here once and reused by the top level.
package button_conditioner_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_REPEAT_DELAY    = 64;
    localparam int DEFAULT_REPEAT_PERIOD   = 16;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2_width(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-flop synchronizer, saturating debounce counter and rising-edge one-shot.
// Auto-repeat logic exists only when BTN_AUTOREPEAT_EN is defined.
module button_conditioner_debounce_channel
    import button_conditioner_pkg::*;
#(
`ifdef BTN_AUTOREPEAT_EN
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
`endif
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic pulse
);

    localparam int            CW         = clog2_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;
    logic          accept;
    logic          rise;

    // accept is true on the edge where the new level is taken; rise is the 0->1 case.
    assign accept = (sync2 != level) && (count == COUNT_LAST);
    assign rise   = accept && sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            count <= '0;
        end else if (count == COUNT_LAST) begin
            level <= sync2;
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = clog2_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_count;
    logic          repeating;
    logic          repeat_fire;

    // A release being accepted on this edge suppresses any repeat that would coincide with it.
    assign repeat_fire = level && !accept &&
                         (rep_count == (repeating ? PERIOD_LAST : DELAY_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_count <= '0;
            repeating <= 1'b0;
        end else if (!level || accept) begin
            rep_count <= '0;
            repeating <= 1'b0;
        end else if (repeat_fire) begin
            rep_count <= '0;
            repeating <= 1'b1;
        end else begin
            rep_count <= rep_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse <= 1'b0;
        end else begin
            pulse <= rise || repeat_fire;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse <= 1'b0;
        end else begin
            pulse <= rise;
        end
    end
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTNS raw push-buttons into debounced Level and one-cycle Pulse outputs.
// Define BTN_AUTOREPEAT_EN to add auto-repeat pulses while a button is held.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTNS        = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [NUM_BTNS-1:0] Btn,
    output logic [NUM_BTNS-1:0] Level,
    output logic [NUM_BTNS-1:0] Pulse
);

    // Channels are fully independent copies with no shared state.
    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_channel
        button_conditioner_debounce_channel #(
`ifdef BTN_AUTOREPEAT_EN
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_channel (
            .clk   (Clk),
            .rst_n (Rst_n),
            .btn   (Btn[i]),
            .level (Level[i]),
            .pulse (Pulse[i])
        );
    end

endmodule
